// File: rtl/ram_pkg.sv
// Shared definitions for the sized data/instruction RAM: access size codes,
// controller state encoding and the sign-extension flag position in MS_2_0.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MS_SIGNED = 2;

    // A half must start on an even byte, a word on a multiple of four;
    // size code 11 behaves as a word.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lowAddr);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lowAddr[0];
            default: return (lowAddr != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/ram_sized_extend.sv
// Read-side lane assembly: takes the four bytes starting at the access
// address (first byte in the top lane, big-endian) and right-justifies the
// byte or half-word, filling the upper bits with zero or the sign bit.
module ram_sized_extend
    import ram_pkg::*;
(
    input  logic [31:0] bytes_i,
    input  logic [1:0]  size_i,
    input  logic        signExt_i,
    output logic [31:0] data_o
);

    // The accessed data's MSB is always bytes_i[31] because the first byte is the most significant
    always_comb begin
        data_o = bytes_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{signExt_i & bytes_i[31]}}, bytes_i[31:24]};
            SZ_HALF: data_o = {{16{signExt_i & bytes_i[31]}}, bytes_i[31:16]};
            default: data_o = bytes_i;
        endcase
    end

endmodule

// File: rtl/ram_sized_mem.sv
// Byte-addressable RAM with byte/half/word access over the MOV/MOC
// handshake and a configurable number of wait states. Big-endian lanes,
// addresses wrap modulo the depth.
// Optional build macro ALIGN_CHECK_EN adds an ERR output that flags
// misaligned half/word accesses, which then complete without effect.
module ram_sized_mem
    import ram_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              MOV,
    input  logic              ReadWrite,
    input  logic [2:0]        MS_2_0,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [31:0]       Address,
    output logic              MOC,
`ifdef ALIGN_CHECK_EN
    output logic              ERR,
`endif
    output logic [DATA_W-1:0] DataOut
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [0:DEPTH-1];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        ms_q, ms_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              moc_q, moc_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              bad_q, bad_d;

    logic              badReq;
    logic              memWe;
    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic [31:0]       rdBytes;
    logic [31:0]       rdData;
    logic              unusedAddrHi;

    assign unusedAddrHi = ^Address[31:ADDR_W];

`ifdef ALIGN_CHECK_EN
    assign badReq = isMisaligned(MS_2_0[1:0], Address[1:0]);
    assign ERR    = moc_q & bad_q;
`else
    assign badReq = 1'b0;
`endif

    assign addr1 = addr_q + ADDR_W'(1);
    assign addr2 = addr_q + ADDR_W'(2);
    assign addr3 = addr_q + ADDR_W'(3);

    assign rdBytes = {mem[addr_q], mem[addr1], mem[addr2], mem[addr3]};

    ram_sized_extend u_extend (
        .bytes_i   (rdBytes),
        .size_i    (ms_q[1:0]),
        .signExt_i (ms_q[MS_SIGNED]),
        .data_o    (rdData)
    );

    // Handshake controller: capture in IDLE, optional wait count, one-cycle access, hold MOC until MOV drops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ms_d    = ms_q;
        rw_d    = rw_q;
        din_d   = din_q;
        moc_d   = moc_q;
        dout_d  = dout_q;
        bad_d   = bad_q;
        memWe   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d = Address[ADDR_W-1:0];
                    ms_d   = MS_2_0;
                    rw_d   = ReadWrite;
                    din_d  = DataIn;
                    bad_d  = badReq;
                    cnt_d  = 4'd0;
                    if ((WAIT_STATES > 0) && !badReq) begin
                        state_d = WAIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (!MOV) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q == 4'(WAIT_STATES - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACCESS: begin
                moc_d   = 1'b1;
                state_d = DONE;
                if (!bad_q) begin
                    if (rw_q) begin
                        dout_d = rdData;
                    end else begin
                        memWe = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!MOV) begin
                    moc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller and request registers; memory contents are deliberately not part of reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            ms_q    <= 3'd0;
            rw_q    <= 1'b0;
            din_q   <= '0;
            moc_q   <= 1'b0;
            dout_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ms_q    <= ms_d;
            rw_q    <= rw_d;
            din_q   <= din_d;
            moc_q   <= moc_d;
            dout_q  <= dout_d;
            bad_q   <= bad_d;
        end
    end

    // Byte-lane write commit: the lowest bytes of DataIn land at the highest addresses
    always_ff @(posedge CLK) begin
        if (memWe) begin
            case (ms_q[1:0])
                SZ_BYTE: begin
                    mem[addr_q] <= din_q[7:0];
                end
                SZ_HALF: begin
                    mem[addr_q] <= din_q[15:8];
                    mem[addr1]  <= din_q[7:0];
                end
                default: begin
                    mem[addr_q] <= din_q[31:24];
                    mem[addr1]  <= din_q[23:16];
                    mem[addr2]  <= din_q[15:8];
                    mem[addr3]  <= din_q[7:0];
                end
            endcase
        end
    end

    assign MOC     = moc_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_ram_sized_mem.sv
// Testbench for ram_sized_mem: one instance with no wait states and one
// with three, both checked against a byte-array model of the memory.
module tb_ram_sized_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstN;
    logic [1:0]  mov;
    logic [1:0]  rw;
    logic [1:0]  moc;
    logic [2:0]  ms   [2];
    logic [31:0] din  [2];
    logic [31:0] addr [2];
    logic [31:0] dout [2];
`ifdef ALIGN_CHECK_EN
    logic [1:0]  err;
`endif

    ram_sized_mem #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .CLK       (clk),
        .RESET_N   (rstN[0]),
        .MOV       (mov[0]),
        .ReadWrite (rw[0]),
        .MS_2_0    (ms[0]),
        .DataIn    (din[0]),
        .Address   (addr[0]),
        .MOC       (moc[0]),
`ifdef ALIGN_CHECK_EN
        .ERR       (err[0]),
`endif
        .DataOut   (dout[0])
    );

    ram_sized_mem #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(3)) dut3 (
        .CLK       (clk),
        .RESET_N   (rstN[1]),
        .MOV       (mov[1]),
        .ReadWrite (rw[1]),
        .MS_2_0    (ms[1]),
        .DataIn    (din[1]),
        .Address   (addr[1]),
        .MOC       (moc[1]),
`ifdef ALIGN_CHECK_EN
        .ERR       (err[1]),
`endif
        .DataOut   (dout[1])
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  model [2][256];
    logic [31:0] lastRead [2];
    int          waitStates [2] = '{0, 3};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dutMem(input int idx, input logic [7:0] a);
        if (idx == 0) return dut0.mem[a];
        return dut3.mem[a];
    endfunction

    task automatic preload(input int idx, input logic [7:0] a, input logic [7:0] v);
        model[idx][a] = v;
        if (idx == 0) dut0.mem[a] = v;
        else          dut3.mem[a] = v;
    endtask

    function automatic int sizeBytes(input logic [2:0] msv);
        if (msv[1:0] == 2'b00) return 1;
        if (msv[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [2:0] msv, input int a);
`ifdef ALIGN_CHECK_EN
        if (sizeBytes(msv) == 2) return (a % 2) != 0;
        if (sizeBytes(msv) == 4) return (a % 4) != 0;
`endif
        return (msv == 3'd7) && (a < 0);
    endfunction

    // Big-endian assembly of n bytes, then arithmetic sign fill for narrow signed reads
    function automatic logic [31:0] expectRead(input int idx, input int a, input logic [2:0] msv);
        logic [31:0] val;
        int n;
        n   = sizeBytes(msv);
        val = 32'd0;
        for (int i = 0; i < n; i++) val = (val << 8) | 32'(model[idx][(a + i) % 256]);
        if (msv[2] && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
        return val;
    endfunction

    task automatic applyStimulus(input int idx, input bit isRead, input logic [2:0] msv,
                                 input logic [31:0] addrv, input logic [31:0] dinv,
                                 input int hold, input string tag);
        int          a;
        int          edges;
        int          n;
        bit          mis;
        logic [31:0] exp;
        a     = int'(addrv[7:0]);
        mis   = misaligned(msv, a);
        edges = 0;
        rw[idx]   = isRead;
        ms[idx]   = msv;
        addr[idx] = addrv;
        din[idx]  = dinv;
        mov[idx]  = 1'b1;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (moc[idx] !== 1'b1 && edges < 50);
        checkOutput({tag, " latency"}, 32'(edges), 32'(mis ? 2 : 2 + waitStates[idx]));
        if (mis) begin
            exp = lastRead[idx];
        end else if (isRead) begin
            exp = expectRead(idx, a, msv);
            lastRead[idx] = exp;
        end else begin
            exp = lastRead[idx];
            n   = sizeBytes(msv);
            for (int i = 0; i < n; i++) model[idx][(a + i) % 256] = 8'(dinv >> (8 * (n - 1 - i)));
        end
        checkOutput({tag, " data"}, dout[idx], exp);
`ifdef ALIGN_CHECK_EN
        checkOutput({tag, " err"}, 32'(err[idx]), 32'(mis));
`endif
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            checkOutput({tag, " moc hold"}, 32'(moc[idx]), 32'd1);
        end
        mov[idx] = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, " moc clear"}, 32'(moc[idx]), 32'd0);
`ifdef ALIGN_CHECK_EN
        checkOutput({tag, " err clear"}, 32'(err[idx]), 32'd0);
`endif
    endtask

    task automatic compareMemory(input int idx, input string tag);
        for (int i = 0; i < 256; i++) checkOutput(tag, 32'(dutMem(idx, 8'(i))), 32'(model[idx][i]));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mov[k]  = 1'b0;
            rw[k]   = 1'b0;
            ms[k]   = 3'd0;
            din[k]  = 32'd0;
            addr[k] = 32'd0;
            lastRead[k] = 32'd0;
        end
        rstN = 2'b11;
        #2 rstN = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset moc", 32'(moc[k]), 32'd0);
            checkOutput("reset dout", dout[k], 32'd0);
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) preload(k, 8'(i), 8'($urandom));
        @(posedge clk); #1;
        rstN = 2'b11;
        @(posedge clk); #1;

        // Directed checks on both instances
        for (int k = 0; k < 2; k++) begin
            preload(k, 8'd5, 8'hA5);
            applyStimulus(k, 1'b1, 3'b000, 32'd5, 32'd0, 1, "byte zext");
            checkOutput("byte zext const", dout[k], 32'h000000A5);
            applyStimulus(k, 1'b1, 3'b100, 32'hFFFF_FF05, 32'd0, 0, "byte sext");
            checkOutput("byte sext const", dout[k], 32'hFFFFFFA5);
            preload(k, 8'd14, 8'h80);
            preload(k, 8'd15, 8'h01);
            applyStimulus(k, 1'b1, 3'b101, 32'd14, 32'd0, 0, "half sext");
            checkOutput("half sext const", dout[k], 32'hFFFF8001);
            applyStimulus(k, 1'b1, 3'b001, 32'd14, 32'd0, 2, "half zext");
            checkOutput("half zext const", dout[k], 32'h00008001);
        end

`ifndef ALIGN_CHECK_EN
        preload(0, 8'd12, 8'h5A);
        preload(0, 8'd17, 8'h3C);
        applyStimulus(0, 1'b0, 3'b010, 32'd13, 32'hC0000001, 0, "word write");
        checkOutput("word write dout kept", dout[0], 32'h00008001);
        applyStimulus(0, 1'b1, 3'b110, 32'd13, 32'd0, 0, "word read");
        checkOutput("word read const", dout[0], 32'hC0000001);
        checkOutput("mem13", 32'(dutMem(0, 8'd13)), 32'h000000C0);
        checkOutput("mem16", 32'(dutMem(0, 8'd16)), 32'h00000001);
        checkOutput("mem12", 32'(dutMem(0, 8'd12)), 32'h0000005A);
        checkOutput("mem17", 32'(dutMem(0, 8'd17)), 32'h0000003C);
        applyStimulus(0, 1'b0, 3'b001, 32'd255, 32'h1234BEEF, 0, "half wrap");
        checkOutput("mem255", 32'(dutMem(0, 8'd255)), 32'h000000BE);
        checkOutput("mem0", 32'(dutMem(0, 8'd0)), 32'h000000EF);
`else
        applyStimulus(0, 1'b0, 3'b010, 32'd2, 32'hDEADBEEF, 0, "align word write");
        compareMemory(0, "align mem");
`endif

        // Abort on the wait-state instance: MOV dropped after two edges of a write
        preload(1, 8'd40, 8'h11);
        preload(1, 8'd41, 8'h22);
        preload(1, 8'd42, 8'h33);
        preload(1, 8'd43, 8'h44);
        rw[1] = 1'b0; ms[1] = 3'b010; addr[1] = 32'd40; din[1] = 32'hAABBCCDD; mov[1] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("abort moc early", 32'(moc[1]), 32'd0);
        mov[1] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("abort moc late", 32'(moc[1]), 32'd0);
        for (int i = 40; i < 44; i++) checkOutput("abort mem", 32'(dutMem(1, 8'(i))), 32'(model[1][i]));
        applyStimulus(1, 1'b1, 3'b000, 32'd41, 32'd0, 0, "after abort");

        // Reset in the middle of the wait count
        rw[1] = 1'b0; ms[1] = 3'b010; addr[1] = 32'd60; din[1] = 32'h01020304; mov[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rstN[1] = 1'b0;
        #1;
        checkOutput("midwait reset moc", 32'(moc[1]), 32'd0);
        checkOutput("midwait reset dout", dout[1], 32'd0);
        lastRead[1] = 32'd0;
        mov[1] = 1'b0;
        @(posedge clk); #1;
        rstN[1] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("midwait moc idle", 32'(moc[1]), 32'd0);
        for (int i = 60; i < 64; i++) checkOutput("midwait mem", 32'(dutMem(1, 8'(i))), 32'(model[1][i]));

        // Randomized traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 80; t++) begin
                applyStimulus(k, 1'($urandom), 3'($urandom), 32'($urandom), 32'($urandom),
                              int'($urandom_range(0, 2)), "random");
            end
            compareMemory(k, "final mem");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sized_mem.md
Name: ram_sized_mem

Overview:
Parametrised successor to the 256x8 data RAM, for use as the CPU's byte-addressable data/instruction memory. Supports byte, half-word and word access with sign or zero extension on reads. Uses the existing MOV/MOC handshake, with a configurable number of wait states. Big-endian: the byte at Address is the most significant byte of a half-word or word.

Parameters:
ADDR_W, 8, address bits used; depth = 2**ADDR_W bytes
DATA_W, 32, bus width; fixed at 32 (byte/half/word lanes)
WAIT_STATES, 0, extra cycles between request capture and MOC (0..15)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
MOV  input  1  memory operation request; held high until MOC
ReadWrite  input  1  1 = read, 0 = write
MS_2_0  input  3  [1:0] size: 00 byte, 01 half, 10 word, 11 treated as word; [2] 1 = sign-extend read
DataIn  input  32  write data, right-justified
Address  input  32  byte address; only [ADDR_W-1:0] used
MOC  output  1  operation complete
DataOut  output  32  read data, right-justified and extended

Behaviour:
- Reset (async, RESET_N=0): state IDLE, MOC=0, DataOut=0, wait counter=0. Memory contents are not cleared.
- Memory: byte array named mem[0:2**ADDR_W-1]. Benches preload it hierarchically.
- IDLE: at a CLK edge with MOV=1:
  - latch Address[ADDR_W-1:0], MS_2_0, ReadWrite and DataIn;
  - go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: counter counts up from 0; at WAIT_STATES-1 go to ACCESS. If MOV is sampled 0 in WAIT: abort, no write, back to IDLE, MOC stays 0.
- ACCESS (one cycle):
  - write: commit the bytes;
  - read: load DataOut;
  - MOC=1 at the end of this edge; go to DONE.
- DONE: MOC held 1 while MOV=1. The first edge sampling MOV=0 clears MOC and goes to IDLE. A new request needs at least one MOV-low edge.
- Latency: MOV first sampled at edge k means MOC rises after edge k+1+WAIT_STATES.
- Byte lanes, with A = latched address:
  - byte: mem[A] <-> bits[7:0];
  - half: mem[A]=[15:8], mem[A+1]=[7:0];
  - word: mem[A]=[31:24] .. mem[A+3]=[7:0].
- Address arithmetic: A+i wraps modulo 2**ADDR_W. Address bits at ADDR_W and above are ignored.
- Read extension: upper bits get the MSB of the accessed data if MS_2_0[2]=1, else zero. A word read ignores MS_2_0[2].
- Writes use only the low 8/16/32 bits of DataIn. Untouched bytes are unchanged.
- DataOut is unchanged by writes and holds the last read value until the next read's ACCESS.
- Simultaneous events: reset dominates everything. A MOV change during ACCESS is ignored; it is evaluated in DONE.
- Unaligned accesses are legal unless the optional feature is enabled.

Optional Feature:
ALIGN_CHECK_EN
- Defined: adds output ERR (1 bit, reset 0). A half access with A[0]=1, or a word access with A[1:0]!=0, is handled as follows:
  - it skips WAIT and goes straight to ACCESS;
  - no write is committed and DataOut is unchanged;
  - MOC and ERR are asserted together and both clear with MOC.
- Undefined: no ERR port; unaligned accesses proceed byte-wise as described in Behaviour.

Decomposition:
- Shared package ram_pkg:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding IDLE/WAIT/ACCESS/DONE;
  - bit-index constant MS_SIGNED=2.
- One natural sub-module, ram_sized_extend: combinational lane assembly plus sign/zero extension for reads.
- FSM, counter and storage stay in ram_sized_mem.

Test Plan:
- Preload mem[5]=8'hA5, WAIT_STATES=0, read byte MS=000 at 5 -> DataOut=32'h000000A5; MOC high 1 cycle after MOV sampled.
- Same location, MS=100 -> DataOut=32'hFFFFFFA5.
- Preload mem[14..15]=8'h80,8'h01, read half MS=101 -> 32'hFFFF8001.
- Same location, MS=001 -> 32'h00008001.
- Write word 32'hC0000001 at 13, then read word at 13:
  - read returns 32'hC0000001;
  - mem[13]=C0, mem[16]=01;
  - mem[12] and mem[17] unchanged.
- ADDR_W=8, write half 16'hBEEF at 255 -> mem[255]=BE, mem[0]=EF (wrap).
- WAIT_STATES=3:
  - read: MOC rises exactly 4 edges after MOV is sampled.
  - Drop MOV after 2 edges on a write: MOC never asserts and memory is unchanged.
  - RESET_N=0 mid-WAIT: MOC=0 and DataOut=0 immediately, with no write.
- With ALIGN_CHECK_EN, word write at 2 -> ERR=1 with MOC, memory unchanged.
